// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, reads instruction memory and offers the word
// downstream over a valid/ready handshake with redirect and flush.
module instr_fetch_unit #(
   parameter logic [31:0] PC_RESET   = 32'h0000_0000,
   parameter int unsigned PC_STEP    = 4,
   parameter int unsigned IMEM_BYTES = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        id_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic        err_misalign
);

   localparam logic [31:0] MASK = 32'(IMEM_BYTES - 1);
   localparam logic [31:0] STEP = 32'(PC_STEP);

   typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

   state_t      state;
   state_t      state_nx;
   logic [31:0] pc;
   logic [31:0] pc_seq;
   logic [31:0] pc_redir;
   logic        free;
   logic        fetch_go;

   assign imem_addr = pc;
   assign pc_seq    = (pc + STEP) & MASK;
   assign pc_redir  = {redirect_pc[31:2], 2'b00} & MASK;
   assign free      = !if_valid || id_ready;
   assign fetch_go  = (state != IDLE) && fetch_en && free && !redirect_valid;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (fetch_en) state_nx = RUN;
         RUN: begin
            if (!fetch_en)
               state_nx = IDLE;
            else if (if_valid && !id_ready)
               state_nx = STALL;
         end
         STALL: if (id_ready) state_nx = fetch_en ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
      // Redirect overrides any stall or drain in progress
      if (redirect_valid)
         state_nx = fetch_en ? RUN : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= PC_RESET;
         if_valid     <= 1'b0;
         if_instr     <= 32'h0;
         if_pc        <= 32'h0;
         if_pc_plus4  <= 32'h0;
         err_misalign <= 1'b0;
      end else begin
         err_misalign <= 1'b0;
         if (redirect_valid) begin
            pc           <= pc_redir;
            if_valid     <= 1'b0;
            err_misalign <= |redirect_pc[1:0];
         end else if (fetch_go) begin
            if_instr    <= imem_rdata;
            if_pc       <= pc;
            if_pc_plus4 <= pc_seq;
            if_valid    <= 1'b1;
            pc          <= pc_seq;
         end else if (free) begin
            if_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, stall, redirect,
// wrap, misalign, fetch_en drain and asynchronous reset.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_en = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic        id_ready = 1'b0;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        err_misalign;

   logic [31:0] mem [64];
   int          n_checks = 0;
   int          n_fail = 0;

   typedef struct {
      bit          fe;
      bit          rdy;
      bit          rv;
      logic [31:0] rpc;
      bit          ev;
      logic [31:0] epc;
      logic [31:0] eaddr;
      bit          ee;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   assign imem_rdata = mem[imem_addr[7:2]];

   instr_fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fetch_en      (fetch_en),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .if_valid      (if_valid),
      .id_ready      (id_ready),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .if_pc_plus4   (if_pc_plus4),
      .err_misalign  (err_misalign)
   );

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(bit fe, bit rdy, bit rv, logic [31:0] rpc,
                               bit ev, logic [31:0] epc,
                               logic [31:0] eaddr, bit ee);
      vec_t v;
      v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
      v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.ee = ee;
      return v;
   endfunction

   task automatic check_word(input string name, input int idx,
                             input logic [31:0] pc);
      logic [31:0] p4;
      p4 = (pc + 32'd4) & 32'hFF;
      check({name, ".pc"}, idx, if_pc, pc);
      check({name, ".instr"}, idx, if_instr, mem[pc[7:2]]);
      check({name, ".pc4"}, idx, if_pc_plus4, p4);
   endtask

   task automatic step(input bit fe, input bit rdy);
      fetch_en = fe;
      id_ready = rdy;
      redirect_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++)
         mem[i] = 32'h1000_0000 + i * 32'h0101;
      mem[0] = 32'h0000_0000;
      mem[1] = 32'h8C21_0001;

      // T1: reset held from time zero
      #2;
      check("rst.valid", 0, {31'b0, if_valid}, 32'h0);
      check("rst.addr", 0, imem_addr, 32'h0);
      check("rst.instr", 0, if_instr, 32'h0);
      check("rst.err", 0, {31'b0, err_misalign}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      //            fe rdy rv rpc          ev epc         eaddr       ee
      vecs.push_back(mk(1, 1, 0, 32'h0,    0, 32'h0,  32'h00, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0,    1, 32'h00, 32'h04, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0,    1, 32'h04, 32'h08, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0,    1, 32'h08, 32'h0C, 0));
      vecs.push_back(mk(1, 0, 0, 32'h0,    1, 32'h08, 32'h0C, 0));
      vecs.push_back(mk(1, 0, 0, 32'h0,    1, 32'h08, 32'h0C, 0));
      vecs.push_back(mk(1, 0, 0, 32'h0,    1, 32'h08, 32'h0C, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0,    1, 32'h0C, 32'h10, 0));
      vecs.push_back(mk(1, 0, 0, 32'h0,    1, 32'h0C, 32'h10, 0));
      vecs.push_back(mk(1, 0, 1, 32'h1C,   0, 32'h0,  32'h1C, 0));
      vecs.push_back(mk(1, 0, 0, 32'h0,    1, 32'h1C, 32'h20, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0,    1, 32'h20, 32'h24, 0));
      vecs.push_back(mk(1, 1, 1, 32'hF4,   0, 32'h0,  32'hF4, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0,    1, 32'hF4, 32'hF8, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0,    1, 32'hF8, 32'hFC, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0,    1, 32'hFC, 32'h00, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0,    1, 32'h00, 32'h04, 0));
      vecs.push_back(mk(1, 1, 1, 32'h1E,   0, 32'h0,  32'h1C, 1));
      vecs.push_back(mk(1, 1, 0, 32'h0,    1, 32'h1C, 32'h20, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0,    1, 32'h20, 32'h24, 0));
      vecs.push_back(mk(1, 1, 1, 32'h104,  0, 32'h0,  32'h04, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0,    1, 32'h04, 32'h08, 0));

      foreach (vecs[i]) begin
         fetch_en = vecs[i].fe;
         id_ready = vecs[i].rdy;
         redirect_valid = vecs[i].rv;
         redirect_pc = vecs[i].rpc;
         @(posedge clk);
         #1;
         check("valid", i, {31'b0, if_valid}, {31'b0, vecs[i].ev});
         check("addr", i, imem_addr, vecs[i].eaddr);
         check("err", i, {31'b0, err_misalign}, {31'b0, vecs[i].ee});
         if (vecs[i].ev)
            check_word("word", i, vecs[i].epc);
      end
      redirect_valid = 1'b0;

      // T6a: fetch_en drop drains the slot, pc held
      step(0, 1);
      check("drain.valid", 0, {31'b0, if_valid}, 32'h0);
      check("drain.addr", 0, imem_addr, 32'h08);
      step(0, 1);
      check("drain.addr", 1, imem_addr, 32'h08);
      step(1, 0);
      check("restart.valid", 0, {31'b0, if_valid}, 32'h0);
      step(1, 0);
      check("restart.valid", 1, {31'b0, if_valid}, 32'h1);
      check_word("restart", 1, 32'h08);
      // word must stay valid until accepted even with fetch_en low
      step(0, 0);
      check("hold.valid", 0, {31'b0, if_valid}, 32'h1);
      check_word("hold", 0, 32'h08);
      step(0, 1);
      check("hold.valid", 1, {31'b0, if_valid}, 32'h0);
      check("hold.addr", 1, imem_addr, 32'h0C);

      // T6b: asynchronous reset in the middle of a stall
      step(1, 1);
      step(1, 1);
      check("pre.valid", 0, {31'b0, if_valid}, 32'h1);
      check_word("pre", 0, 32'h0C);
      step(1, 0);
      step(1, 0);
      check("stall.addr", 0, imem_addr, 32'h10);
      #2 rst_n = 1'b0;
      #1;
      check("arst.valid", 0, {31'b0, if_valid}, 32'h0);
      check("arst.addr", 0, imem_addr, 32'h0);
      check("arst.pc", 0, if_pc, 32'h0);
      check("arst.instr", 0, if_instr, 32'h0);
      check("arst.pc4", 0, if_pc_plus4, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 1);
      check("rerun.valid", 0, {31'b0, if_valid}, 32'h0);
      step(1, 1);
      check("rerun.valid", 1, {31'b0, if_valid}, 32'h1);
      check_word("rerun", 1, 32'h00);
      step(1, 1);
      check_word("rerun", 2, 32'h04);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
